// File: rtl/axis_rx_msix_decoder_if.sv
// PCIe SS AXI-S stream bundle: 512-bit data beat plus vendor sideband carrying the DM-encoding flag.
interface pcie_ss_axis_if;
    logic         tvalid;
    logic         tready;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic [9:0]   tuser_vendor;

    modport sink (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser_vendor,
        output tready
    );

    modport source (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tuser_vendor,
        input  tready
    );
endinterface

// File: rtl/axis_rx_msix_decoder.sv
// Decodes DM-encoded interrupt headers from the RX stream, filters by function and queues vector
// numbers for an interrupt consumer; every other packet is consumed and dropped.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_SOP  | next accepted beat is a packet header; classify it
//  ST_BODY | discard remaining beats of the current packet until tlast
module axis_rx_msix_decoder #(
    parameter logic [2:0]  PF_NUM     = 3'd0,
    parameter logic [10:0] VF_NUM     = 11'd0,
    parameter logic        VF_ACTIVE  = 1'b0,
    parameter bit          MATCH_FUNC = 1'b1,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pcie_ss_axis_if.sink  axis_rx_if,
    output logic          msix_strb,
    output logic [15:0]   msix_num,
    input  logic          msix_ready,
    output logic          axis_rx_error,
    output logic [31:0]   intr_cnt,
    output logic [31:0]   drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] DM_INTR = 8'h30;
    localparam int TUSER_DM_ENCODING_BIT = 0;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    localparam logic [0:0] ST_SOP  = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]       state;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Header fields: fmt_type[31:24], vector_num[47:32], pf_num[66:64], vf_num[77:67], vf_active[78]
    logic [7:0]  hdr_fmt_type;
    logic [15:0] hdr_vector;
    logic [2:0]  hdr_pf;
    logic [10:0] hdr_vf;
    logic        hdr_vf_active;
    logic        dm_bit;

    assign hdr_fmt_type  = axis_rx_if.tdata[31:24];
    assign hdr_vector    = axis_rx_if.tdata[47:32];
    assign hdr_pf        = axis_rx_if.tdata[66:64];
    assign hdr_vf        = axis_rx_if.tdata[77:67];
    assign hdr_vf_active = axis_rx_if.tdata[78];
    assign dm_bit        = axis_rx_if.tuser_vendor[TUSER_DM_ENCODING_BIT];

    logic unused_bits;
    assign unused_bits = ^{axis_rx_if.tkeep, axis_rx_if.tuser_vendor[9:1],
                           axis_rx_if.tdata[511:79], axis_rx_if.tdata[63:48],
                           axis_rx_if.tdata[23:0]};

    logic fifo_full;
    logic ready;
    logic beat;
    logic hdr_fire;
    logic func_ok;
    logic is_intr_fmt;
    logic push;
    logic pop;
    logic hdr_err;

    assign fifo_full   = (count == CNT_FULL);
    assign ready       = rst_n && ((state == ST_BODY) || !fifo_full);
    assign axis_rx_if.tready = ready;
    assign beat        = axis_rx_if.tvalid && ready;
    assign hdr_fire    = beat && (state == ST_SOP);
    assign is_intr_fmt = (hdr_fmt_type == DM_INTR);
    assign func_ok     = !MATCH_FUNC || ((hdr_pf == PF_NUM) && (hdr_vf == VF_NUM) &&
                                         (hdr_vf_active == VF_ACTIVE));
    assign push        = hdr_fire && dm_bit && is_intr_fmt && func_ok;
    assign hdr_err     = hdr_fire && is_intr_fmt && !dm_bit;

    assign msix_strb = (count != '0);
    assign msix_num  = msix_strb ? mem[rd_ptr] : 16'h0000;
    assign pop       = msix_strb && msix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SOP;
        end else if (beat) begin
            state <= axis_rx_if.tlast ? ST_SOP : ST_BODY;
        end
    end

    // Storage needs no reset; msix_num is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= hdr_vector;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_rx_error <= 1'b0;
            intr_cnt      <= '0;
            drop_cnt      <= '0;
        end else begin
            axis_rx_error <= hdr_err;
            if (push && (intr_cnt != CNT_MAX)) begin
                intr_cnt <= intr_cnt + 32'd1;
            end
            if (hdr_fire && !push && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_rx_msix_decoder.sv
// Directed bench for the RX MSI-X decoder: one task per scenario, hand-computed expectations.
module tb_axis_rx_msix_decoder;
    localparam logic [7:0] DM_INTR = 8'h30;
    localparam logic [7:0] DM_MWR  = 8'h60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         tv = 1'b0;
    logic [511:0] td = '0;
    logic         tl = 1'b0;
    logic [9:0]   tu = '0;
    logic         sel = 1'b0;
    logic         rdy0 = 1'b0;
    logic         rdy1 = 1'b0;

    pcie_ss_axis_if rx0 ();
    pcie_ss_axis_if rx1 ();

    assign rx0.tvalid = tv & ~sel;
    assign rx0.tdata = td;
    assign rx0.tkeep = '1;
    assign rx0.tlast = tl;
    assign rx0.tuser_vendor = tu;
    assign rx1.tvalid = tv & sel;
    assign rx1.tdata = td;
    assign rx1.tkeep = '1;
    assign rx1.tlast = tl;
    assign rx1.tuser_vendor = tu;

    logic        strb0, err0, strb1, err1;
    logic [15:0] num0, num1;
    logic [31:0] icnt0, dcnt0, icnt1, dcnt1;

    axis_rx_msix_decoder #(.PF_NUM(3'd2), .VF_NUM(11'd5), .VF_ACTIVE(1'b0),
                           .MATCH_FUNC(1'b1), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .axis_rx_if(rx0),
        .msix_strb(strb0), .msix_num(num0), .msix_ready(rdy0),
        .axis_rx_error(err0), .intr_cnt(icnt0), .drop_cnt(dcnt0));

    axis_rx_msix_decoder #(.PF_NUM(3'd2), .VF_NUM(11'd5), .VF_ACTIVE(1'b0),
                           .MATCH_FUNC(1'b0), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .axis_rx_if(rx1),
        .msix_strb(strb1), .msix_num(num1), .msix_ready(rdy1),
        .axis_rx_error(err1), .intr_cnt(icnt1), .drop_cnt(dcnt1));

    int compared = 0;
    int mismatched = 0;

    function automatic logic [511:0] mk_hdr(input logic [7:0] fmt, input logic [15:0] vec,
                                            input logic [2:0] pf, input logic [10:0] vf,
                                            input logic vfa);
        logic [511:0] d;
        d = '0;
        d[511:256] = {8{32'hDEAD_BEEF}};
        d[31:24] = fmt;
        d[47:32] = vec;
        d[66:64] = pf;
        d[77:67] = vf;
        d[78]    = vfa;
        return d;
    endfunction

    // Presents one beat and returns after the edge that accepted it; waits counts stalled cycles.
    task automatic send(input logic [511:0] d, input logic [9:0] u, input logic last,
                        output int waits);
        logic r;
        waits = 0;
        td = d; tu = u; tl = last; tv = 1'b1;
        r = sel ? rx1.tready : rx0.tready;
        while (!r && waits < 200) begin
            @(posedge clk); #1;
            waits++;
            r = sel ? rx1.tready : rx0.tready;
        end
        if (!r) begin
            compared++; mismatched++;
            $display("FAIL send_timeout: tready=%b required=1 after %0d cycles", r, waits);
        end
        @(posedge clk); #1;
        tv = 1'b0;
    endtask

    task automatic apply_reset();
        tv = 1'b0; sel = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        compared++;
        if ({strb0, num0, err0, icnt0, dcnt0, rx0.tready} !== {1'b0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_outputs: strb=%b num=%h err=%b icnt=%0d dcnt=%0d tready=%b required all 0",
                     strb0, num0, err0, icnt0, dcnt0, rx0.tready);
        end
        apply_reset();
        compared++;
        if (rx0.tready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release_tready: got %b required 1", rx0.tready);
        end
    endtask

    task automatic test_single();
        int w;
        apply_reset();
        rdy0 = 1'b1;
        send(mk_hdr(DM_INTR, 16'h0005, 3'd2, 11'd5, 1'b0), 10'h001, 1'b1, w);
        compared++;
        if (strb0 !== 1'b1 || num0 !== 16'h0005) begin
            mismatched++;
            $display("FAIL single_vector: strb=%b num=%h required strb=1 num=0005", strb0, num0);
        end
        compared++;
        if (icnt0 !== 32'd1 || dcnt0 !== 32'd0) begin
            mismatched++;
            $display("FAIL single_counts: icnt=%0d dcnt=%0d required 1/0", icnt0, dcnt0);
        end
        @(posedge clk); #1;
        compared++;
        if (strb0 !== 1'b0) begin
            mismatched++;
            $display("FAIL single_pop: strb=%b required 0", strb0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        apply_reset();
        rdy0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(mk_hdr(DM_INTR, 16'(i), 3'd2, 11'd5, 1'b0), 10'h001, 1'b1, w);
        end
        td = mk_hdr(DM_INTR, 16'h0008, 3'd2, 11'd5, 1'b0); tu = 10'h001; tl = 1'b1; tv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (rx0.tready !== 1'b0) begin
                mismatched++;
                $display("FAIL full_tready: cycle %0d tready=%b required 0", c, rx0.tready);
            end
            @(posedge clk); #1;
        end
        rdy0 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            compared++;
            if (strb0 !== 1'b1 || num0 !== 16'(i)) begin
                mismatched++;
                $display("FAIL drain_order: idx %0d strb=%b num=%h required strb=1 num=%h",
                         i, strb0, num0, 16'(i));
            end
            @(posedge clk); #1;
            if (i == 1) tv = 1'b0;
        end
        compared++;
        if (strb0 !== 1'b0 || icnt0 !== 32'd9 || dcnt0 !== 32'd0) begin
            mismatched++;
            $display("FAIL drain_end: strb=%b icnt=%0d dcnt=%0d required 0/9/0", strb0, icnt0, dcnt0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int total;
        apply_reset();
        rdy0 = 1'b1;
        total = 0;
        send(mk_hdr(DM_MWR, 16'h0033, 3'd2, 11'd5, 1'b0), 10'h001, 1'b0, w);
        total += w;
        send(mk_hdr(DM_INTR, 16'h0077, 3'd2, 11'd5, 1'b0), 10'h001, 1'b0, w);
        total += w;
        compared++;
        if (strb0 !== 1'b0) begin
            mismatched++;
            $display("FAIL body_ignored: strb=%b required 0", strb0);
        end
        send({16{32'h1234_5678}}, 10'h3FF, 1'b1, w);
        total += w;
        send(mk_hdr(DM_INTR, 16'h00A0, 3'd2, 11'd5, 1'b0), 10'h001, 1'b1, w);
        total += w;
        compared++;
        if (total !== 0) begin
            mismatched++;
            $display("FAIL body_tready: stalled %0d cycles required 0", total);
        end
        compared++;
        if (strb0 !== 1'b1 || num0 !== 16'h00A0 || icnt0 !== 32'd1 || dcnt0 !== 32'd1) begin
            mismatched++;
            $display("FAIL b2b_result: strb=%b num=%h icnt=%0d dcnt=%0d required 1/00a0/1/1",
                     strb0, num0, icnt0, dcnt0);
        end
        @(posedge clk); #1;
        compared++;
        if (strb0 !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_single: strb=%b required 0", strb0);
        end
    endtask

    task automatic test_func_match();
        int w;
        apply_reset();
        rdy0 = 1'b1;
        send(mk_hdr(DM_INTR, 16'h0042, 3'd3, 11'd5, 1'b0), 10'h001, 1'b1, w);
        repeat (2) begin
            compared++;
            if (strb0 !== 1'b0 || dcnt0 !== 32'd1 || icnt0 !== 32'd0) begin
                mismatched++;
                $display("FAIL func_mismatch: strb=%b dcnt=%0d icnt=%0d required 0/1/0", strb0, dcnt0, icnt0);
            end
            @(posedge clk); #1;
        end
        sel = 1'b1;
        rdy1 = 1'b0;
        send(mk_hdr(DM_INTR, 16'h0042, 3'd3, 11'd5, 1'b0), 10'h001, 1'b1, w);
        compared++;
        if (strb1 !== 1'b1 || num1 !== 16'h0042 || icnt1 !== 32'd1 || dcnt1 !== 32'd0) begin
            mismatched++;
            $display("FAIL func_any: strb=%b num=%h icnt=%0d dcnt=%0d required 1/0042/1/0",
                     strb1, num1, icnt1, dcnt1);
        end
        sel = 1'b0;
    endtask

    task automatic test_error();
        int w;
        apply_reset();
        rdy0 = 1'b1;
        send(mk_hdr(DM_INTR, 16'h0011, 3'd2, 11'd5, 1'b0), 10'h3FE, 1'b1, w);
        compared++;
        if (err0 !== 1'b1) begin
            mismatched++;
            $display("FAIL error_pulse: err=%b required 1", err0);
        end
        @(posedge clk); #1;
        compared++;
        if (err0 !== 1'b0 || strb0 !== 1'b0 || dcnt0 !== 32'd1 || icnt0 !== 32'd0) begin
            mismatched++;
            $display("FAIL error_after: err=%b strb=%b dcnt=%0d icnt=%0d required 0/0/1/0",
                     err0, strb0, dcnt0, icnt0);
        end
    endtask

    task automatic test_stream_and_reset();
        int w;
        int bad;
        apply_reset();
        rdy0 = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            send(mk_hdr(DM_INTR, 16'(i), 3'd2, 11'd5, 1'b0), 10'h001, 1'b1, w);
            if (strb0 !== 1'b1 || num0 !== 16'(i) || w != 0) begin
                bad++;
                $display("FAIL stream_track: idx %0d strb=%b num=%h waits=%0d required 1/%h/0",
                         i, strb0, num0, w, 16'(i));
            end
        end
        compared++;
        if (bad != 0 || icnt0 !== 32'd100) begin
            mismatched++;
            $display("FAIL stream_summary: bad=%0d icnt=%0d required 0/100", bad, icnt0);
        end
        rdy0 = 1'b0;
        @(posedge clk); #1;
        send(mk_hdr(DM_INTR, 16'h0055, 3'd2, 11'd5, 1'b0), 10'h001, 1'b1, w);
        send(mk_hdr(DM_MWR, 16'h0000, 3'd2, 11'd5, 1'b0), 10'h001, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({strb0, num0, err0, icnt0, dcnt0, rx0.tready} !== {1'b0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset: strb=%b num=%h err=%b icnt=%0d dcnt=%0d tready=%b required all 0",
                     strb0, num0, err0, icnt0, dcnt0, rx0.tready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rdy0 = 1'b1;
        send(mk_hdr(DM_INTR, 16'h0066, 3'd2, 11'd5, 1'b0), 10'h001, 1'b1, w);
        compared++;
        if (strb0 !== 1'b1 || num0 !== 16'h0066 || icnt0 !== 32'd1 || dcnt0 !== 32'd0) begin
            mismatched++;
            $display("FAIL post_reset_header: strb=%b num=%h icnt=%0d dcnt=%0d required 1/0066/1/0",
                     strb0, num0, icnt0, dcnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_func_match();
        test_error();
        test_stream_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
